chip_eval_sequencer: RTL and testbench

CHIP_EVAL_SEQUENCER -- requirements
Module: chip_eval_sequencer

---
 rtl/chip_eval_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_chip_eval_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_eval_sequencer.sv
// ---------------------------------------------------------------------------
// chip_eval_sequencer
//
// Drives one evaluation run of an external notch-filter test chip:
//   1. pulses the chip reset low for RST_CYCLES cycles,
//   2. shifts NUM_COEFFS coefficients into the chip, MSB first,
//   3. for each of NUM_STEPS frequency steps, kicks the ADC and waits for the
//      chip to report the step as evaluated (bounded by TIMEOUT cycles),
//   4. reads READ_WORDS words back from each of the three SRAM selects over a
//      gapped serial stream and presents each one as a captured word.
//
// Ports
//   clk, rst             clock and asynchronous active-high reset
//   kernel_start         run request, sampled only while IDLE or DONE
//   bypass_adc_eval      ADC bypass request, latched when a run starts
//   coeff_word/index     coefficient source and the index being loaded
//   freq_eval_done       chip reports the current frequency step finished
//   serial_out(_valid)   readout bit stream from the chip
//   dut_rst_n, load_en, debug_en, serial_in, sram_select,
//   adc_start, adc_bypass_en           chip control
//   cap_data, cap_sel, cap_valid        deserialized readout word and strobe
//   busy, eval_done, timeout_err        run status
// ---------------------------------------------------------------------------
module chip_eval_sequencer #(
   parameter int COEFF_BITS = 16,
   parameter int NUM_COEFFS = 5,
   parameter int NUM_STEPS  = 64,
   parameter int READ_WORDS = 16,
   parameter int RST_CYCLES = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  kernel_start,
   input  logic                  bypass_adc_eval,
   input  logic [COEFF_BITS-1:0] coeff_word,
   output logic [2:0]            coeff_index,
   input  logic                  freq_eval_done,
   input  logic                  serial_out,
   input  logic                  serial_out_valid,
   output logic                  dut_rst_n,
   output logic                  load_en,
   output logic                  debug_en,
   output logic                  serial_in,
   output logic [1:0]            sram_select,
   output logic                  adc_start,
   output logic                  adc_bypass_en,
   output logic [COEFF_BITS-1:0] cap_data,
   output logic [1:0]            cap_sel,
   output logic                  cap_valid,
   output logic                  busy,
   output logic                  eval_done,
   output logic                  timeout_err
);

   localparam int BIT_W  = (COEFF_BITS > 1) ? $clog2(COEFF_BITS) : 1;
   localparam int RST_W  = $clog2(RST_CYCLES + 1);
   localparam int STEP_W = $clog2(NUM_STEPS + 1);
   localparam int WORD_W = $clog2(READ_WORDS + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      DUT_RST,
      LOAD,
      ADC_KICK,
      WAIT_EVAL,
      READOUT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [RST_W-1:0]      rstCnt_q, rstCnt_d;
   logic [BIT_W-1:0]      bitIdx_q, bitIdx_d;
   logic [2:0]            coeffIdx_q, coeffIdx_d;
   logic [STEP_W-1:0]     stepCnt_q, stepCnt_d;
   logic [TMO_W-1:0]      tmoCnt_q, tmoCnt_d;
   logic [COEFF_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      rdBits_q, rdBits_d;
   logic [WORD_W-1:0]     wordCnt_q, wordCnt_d;
   logic [1:0]            sel_q, sel_d;
   logic [COEFF_BITS-1:0] capData_q, capData_d;
   logic [1:0]            capSel_q, capSel_d;
   logic                  capValid_q, capValid_d;
   logic                  bypass_q, bypass_d;
   logic                  timeoutErr_q, timeoutErr_d;

   // State and datapath registers. Reset is asynchronous so a mid-run reset
   // immediately returns every output to its idle value and throws away any
   // half-assembled readout word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rstCnt_q     <= '0;
         bitIdx_q     <= '0;
         coeffIdx_q   <= '0;
         stepCnt_q    <= '0;
         tmoCnt_q     <= '0;
         shift_q      <= '0;
         rdBits_q     <= '0;
         wordCnt_q    <= '0;
         sel_q        <= '0;
         capData_q    <= '0;
         capSel_q     <= '0;
         capValid_q   <= 1'b0;
         bypass_q     <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rstCnt_q     <= rstCnt_d;
         bitIdx_q     <= bitIdx_d;
         coeffIdx_q   <= coeffIdx_d;
         stepCnt_q    <= stepCnt_d;
         tmoCnt_q     <= tmoCnt_d;
         shift_q      <= shift_d;
         rdBits_q     <= rdBits_d;
         wordCnt_q    <= wordCnt_d;
         sel_q        <= sel_d;
         capData_q    <= capData_d;
         capSel_q     <= capSel_d;
         capValid_q   <= capValid_d;
         bypass_q     <= bypass_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   // Next-state and chip-control decode. Everything holds by default; the
   // control outputs idle at their inactive levels so only the active state
   // has to mention them. The timeout counter only runs while waiting on the
   // chip (step evaluation or readout bits) and a response arriving on the
   // expiry cycle still wins.
   always_comb begin
      state_d      = state_q;
      rstCnt_d     = rstCnt_q;
      bitIdx_d     = bitIdx_q;
      coeffIdx_d   = coeffIdx_q;
      stepCnt_d    = stepCnt_q;
      tmoCnt_d     = tmoCnt_q;
      shift_d      = shift_q;
      rdBits_d     = rdBits_q;
      wordCnt_d    = wordCnt_q;
      sel_d        = sel_q;
      capData_d    = capData_q;
      capSel_d     = capSel_q;
      capValid_d   = 1'b0;
      bypass_d     = bypass_q;
      timeoutErr_d = timeoutErr_q;

      dut_rst_n    = 1'b1;
      load_en      = 1'b0;
      debug_en     = 1'b0;
      serial_in    = 1'b0;
      adc_start    = 1'b0;
      sram_select  = 2'd0;

      case (state_q)
         IDLE, DONE: begin
            if (kernel_start) begin
               state_d      = DUT_RST;
               rstCnt_d     = '0;
               bitIdx_d     = BIT_W'(COEFF_BITS - 1);
               coeffIdx_d   = '0;
               stepCnt_d    = '0;
               tmoCnt_d     = '0;
               shift_d      = '0;
               rdBits_d     = '0;
               wordCnt_d    = '0;
               sel_d        = '0;
               timeoutErr_d = 1'b0;
               bypass_d     = bypass_adc_eval;
            end
         end

         DUT_RST: begin
            dut_rst_n = 1'b0;
            if (rstCnt_q == RST_W'(RST_CYCLES - 1)) begin
               state_d = LOAD;
            end else begin
               rstCnt_d = rstCnt_q + 1'b1;
            end
         end

         LOAD: begin
            load_en   = 1'b1;
            serial_in = coeff_word[bitIdx_q];
            if (bitIdx_q == '0) begin
               bitIdx_d = BIT_W'(COEFF_BITS - 1);
               if (coeffIdx_q == 3'(NUM_COEFFS - 1)) begin
                  coeffIdx_d = '0;
                  state_d    = ADC_KICK;
               end else begin
                  coeffIdx_d = coeffIdx_q + 1'b1;
               end
            end else begin
               bitIdx_d = bitIdx_q - 1'b1;
            end
         end

         ADC_KICK: begin
            adc_start = 1'b1;
            tmoCnt_d  = '0;
            state_d   = WAIT_EVAL;
         end

         WAIT_EVAL: begin
            if (freq_eval_done) begin
               stepCnt_d = stepCnt_q + 1'b1;
               if (stepCnt_q == STEP_W'(NUM_STEPS - 1)) begin
                  state_d   = READOUT;
                  tmoCnt_d  = '0;
                  rdBits_d  = '0;
                  wordCnt_d = '0;
                  sel_d     = '0;
                  shift_d   = '0;
               end else begin
                  state_d = ADC_KICK;
               end
            end else if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
               timeoutErr_d = 1'b1;
               state_d      = DONE;
            end else begin
               tmoCnt_d = tmoCnt_q + 1'b1;
            end
         end

         READOUT: begin
            debug_en    = 1'b1;
            sram_select = sel_q;
            if (serial_out_valid) begin
               shift_d  = {shift_q[COEFF_BITS-2:0], serial_out};
               tmoCnt_d = '0;
               if (rdBits_q == BIT_W'(COEFF_BITS - 1)) begin
                  rdBits_d   = '0;
                  capData_d  = {shift_q[COEFF_BITS-2:0], serial_out};
                  capSel_d   = sel_q;
                  capValid_d = 1'b1;
                  if (wordCnt_q == WORD_W'(READ_WORDS - 1)) begin
                     wordCnt_d = '0;
                     if (sel_q == 2'd2) begin
                        state_d = DONE;
                     end else begin
                        sel_d = sel_q + 1'b1;
                     end
                  end else begin
                     wordCnt_d = wordCnt_q + 1'b1;
                  end
               end else begin
                  rdBits_d = rdBits_q + 1'b1;
               end
            end else if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
               timeoutErr_d = 1'b1;
               rdBits_d     = '0;
               shift_d      = '0;
               state_d      = DONE;
            end else begin
               tmoCnt_d = tmoCnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status and captured-word outputs come straight from registers so they
   // are glitch-free toward the chip and the host.
   always_comb begin
      coeff_index   = coeffIdx_q;
      adc_bypass_en = bypass_q;
      cap_data      = capData_q;
      cap_sel       = capSel_q;
      cap_valid     = capValid_q;
      timeout_err   = timeoutErr_q;
      eval_done     = (state_q == DONE);
      busy          = (state_q != IDLE) && (state_q != DONE);
   end

endmodule

// File: tb/tb_chip_eval_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chip_eval_sequencer
//
// Plays the part of the chip under evaluation around chip_eval_sequencer.
// A chip model answers each ADC kick after a programmable delay and streams
// readout words with optional gaps. Expected readout words are queued when a
// run is issued; a monitor pops and compares them whenever cap_valid fires and
// also tallies load, reset and ADC activity for the end-of-run checks.
// ---------------------------------------------------------------------------
module tb_chip_eval_sequencer;

   localparam int CB     = 16;
   localparam int NC     = 5;
   localparam int NS     = 4;
   localparam int RW     = 2;
   localparam int RC     = 4;
   localparam int TO     = 32;
   localparam int LB     = NC * CB;
   localparam int NWORDS = 3 * RW;

   logic          clk = 1'b0;
   logic          rst;
   logic          kernel_start;
   logic          bypass_adc_eval;
   logic [CB-1:0] coeff_word;
   logic [2:0]    coeff_index;
   logic          freq_eval_done;
   logic          serial_out;
   logic          serial_out_valid;
   logic          dut_rst_n;
   logic          load_en;
   logic          debug_en;
   logic          serial_in;
   logic [1:0]    sram_select;
   logic          adc_start;
   logic          adc_bypass_en;
   logic [CB-1:0] cap_data;
   logic [1:0]    cap_sel;
   logic          cap_valid;
   logic          busy;
   logic          eval_done;
   logic          timeout_err;

   int            testsRun = 0;
   int            testsFailed = 0;

   logic [CB-1:0] coeffs [0:7];
   logic [CB-1:0] words [0:NWORDS-1];
   int            delays [0:NS-1];
   int            gapMode;
   bit            bypassModel;
   logic [CB+1:0] expQ [$];
   logic [LB-1:0] expLoadBits;
   int            expAdc;
   bit            expTimeout;

   int            loadCycles;
   int            rstLow;
   int            adcCount;
   int            capCount;
   int            idxErr;
   int            bypassErr;
   int            selErr;
   int            cyc;
   int            lastAdcCyc;
   int            doneCyc;
   int            bitsSent;
   logic [LB-1:0] loadBits;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   chip_eval_sequencer #(
      .COEFF_BITS (CB),
      .NUM_COEFFS (NC),
      .NUM_STEPS  (NS),
      .READ_WORDS (RW),
      .RST_CYCLES (RC),
      .TIMEOUT    (TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .kernel_start     (kernel_start),
      .bypass_adc_eval  (bypass_adc_eval),
      .coeff_word       (coeff_word),
      .coeff_index      (coeff_index),
      .freq_eval_done   (freq_eval_done),
      .serial_out       (serial_out),
      .serial_out_valid (serial_out_valid),
      .dut_rst_n        (dut_rst_n),
      .load_en          (load_en),
      .debug_en         (debug_en),
      .serial_in        (serial_in),
      .sram_select      (sram_select),
      .adc_start        (adc_start),
      .adc_bypass_en    (adc_bypass_en),
      .cap_data         (cap_data),
      .cap_sel          (cap_sel),
      .cap_valid        (cap_valid),
      .busy             (busy),
      .eval_done        (eval_done),
      .timeout_err      (timeout_err)
   );

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Every output must sit at its idle value while reset is held.
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ctrl"}, {dut_rst_n, load_en, debug_en, serial_in, adc_start, adc_bypass_en}, 6'b100000);
      checkOutput({tag, "_status"}, {busy, eval_done, timeout_err, cap_valid}, 4'b0000);
      checkOutput({tag, "_idx_sel"}, {coeff_index, sram_select, cap_sel}, 7'd0);
      checkOutput({tag, "_cap_data"}, cap_data, 16'd0);
   endtask

   // Fresh random coefficients, readout words and in-budget step delays.
   task automatic randomizeRun();
      for (int i = 0; i < 8; i++) coeffs[i] = CB'($urandom);
      for (int k = 0; k < NWORDS; k++) words[k] = CB'($urandom);
      for (int s = 0; s < NS; s++) delays[s] = $urandom_range(1, TO);
   endtask

   // Works out what the run should produce, queues the expected readout
   // words, then pulses kernel_start for one cycle. A step survives when
   // the chip answers within TO cycles of entering the wait, which starts
   // the cycle after the ADC kick; the first late or missing answer ends the
   // run with a timeout and no readout.
   task automatic applyStimulus(input bit bypass);
      expTimeout = 1'b0;
      expAdc     = 0;
      for (int s = 0; s < NS; s++) begin
         expAdc++;
         if (delays[s] == 0 || delays[s] > TO) begin
            expTimeout = 1'b1;
            break;
         end
      end
      expLoadBits = '0;
      for (int i = 0; i < NC; i++) expLoadBits = {expLoadBits[LB-CB-1:0], coeffs[i]};
      if (!expTimeout) begin
         for (int k = 0; k < NWORDS; k++) expQ.push_back({2'(k / RW), words[k]});
      end
      loadCycles  = 0;
      rstLow      = 0;
      adcCount    = 0;
      capCount    = 0;
      idxErr      = 0;
      selErr      = 0;
      loadBits    = '0;
      bypassModel = bypass;
      @(posedge clk); #3;
      bypass_adc_eval = bypass;
      kernel_start    = 1'b1;
      @(posedge clk); #3;
      kernel_start    = 1'b0;
      bypass_adc_eval = ~bypass;
      bypassErr       = 0;
      doneCyc         = -1;
   endtask

   // Waits (bounded) for eval_done, optionally hammering kernel_start while
   // busy, then checks the whole run against the expectations.
   task automatic finishRun(input string tag, input bit poke);
      int n;
      n = 0;
      while (n < 5000 && !eval_done) begin
         @(posedge clk); #3;
         kernel_start = 1'b0;
         if (!eval_done && poke && busy && (n % 5 == 0)) kernel_start = 1'b1;
         n++;
      end
      kernel_start = 1'b0;
      checkOutput({tag, "_eval_done"}, eval_done, 1'b1);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_load_cycles"}, loadCycles, LB);
      checkOutput({tag, "_coeff_stream"}, loadBits, expLoadBits);
      checkOutput({tag, "_coeff_index_errs"}, idxErr, 0);
      checkOutput({tag, "_rst_low_cycles"}, rstLow, RC);
      checkOutput({tag, "_adc_pulses"}, adcCount, expAdc);
      checkOutput({tag, "_timeout_err"}, timeout_err, expTimeout);
      checkOutput({tag, "_bypass"}, adc_bypass_en, bypassModel);
      checkOutput({tag, "_bypass_errs"}, bypassErr, 0);
      if (expTimeout) begin
         checkOutput({tag, "_timeout_latency"}, doneCyc, lastAdcCyc + 1 + TO);
         checkOutput({tag, "_cap_count"}, capCount, 0);
      end else begin
         checkOutput({tag, "_cap_count"}, capCount, NWORDS);
         checkOutput({tag, "_words_left"}, expQ.size(), 0);
         checkOutput({tag, "_sram_select_errs"}, selErr, 0);
      end
      expQ.delete();
   endtask

   // Chip model: answers each ADC kick after its step delay (0 = never),
   // supplies the coefficient addressed by coeff_index and streams readout
   // words MSB first while debug_en is high, with the configured gap pattern.
   initial begin : chipModel
      int evalCd;
      int stepIdx;
      int k;
      bit toggle;
      bit sendBit;
      evalCd           = 0;
      stepIdx          = 0;
      toggle           = 1'b0;
      bitsSent         = 0;
      freq_eval_done   = 1'b0;
      serial_out       = 1'b0;
      serial_out_valid = 1'b0;
      coeff_word       = '0;
      forever begin
         @(posedge clk); #1;
         freq_eval_done   = 1'b0;
         serial_out_valid = 1'b0;
         serial_out       = 1'b0;
         coeff_word       = coeffs[coeff_index];
         if (rst || !busy) begin
            evalCd   = 0;
            stepIdx  = 0;
            bitsSent = 0;
         end else begin
            if (evalCd > 0) begin
               evalCd--;
               if (evalCd == 0) freq_eval_done = 1'b1;
            end
            if (adc_start) begin
               evalCd = (stepIdx < NS) ? delays[stepIdx] : 0;
               stepIdx++;
            end
            if (debug_en && bitsSent < NWORDS * CB) begin
               k = bitsSent / CB;
               if (sram_select !== 2'(k / RW)) selErr++;
               case (gapMode)
                  0:       sendBit = 1'b1;
                  1:       begin sendBit = toggle; toggle = ~toggle; end
                  default: sendBit = 1'($urandom_range(0, 1));
               endcase
               if (sendBit) begin
                  serial_out       = words[k][CB - 1 - (bitsSent % CB)];
                  serial_out_valid = 1'b1;
                  bitsSent++;
               end else begin
                  serial_out = 1'($urandom);
               end
            end
         end
      end
   end

   // Monitor: tallies chip-facing activity each cycle and pops the
   // scoreboard whenever a captured word is presented.
   initial begin : monitor
      logic [CB+1:0] e;
      cyc = 0;
      forever begin
         @(posedge clk); #2;
         cyc++;
         if (!rst) begin
            if (load_en) begin
               if (coeff_index !== 3'(loadCycles / CB)) idxErr++;
               loadBits = {loadBits[LB-2:0], serial_in};
               loadCycles++;
            end
            if (!dut_rst_n) rstLow++;
            if (adc_start) begin
               adcCount++;
               lastAdcCyc = cyc;
            end
            if ((busy || eval_done) && adc_bypass_en !== bypassModel) bypassErr++;
            if (eval_done && doneCyc < 0) doneCyc = cyc;
            if (cap_valid) begin
               capCount++;
               if (expQ.size() == 0) begin
                  checkOutput("cap_unexpected", cap_valid, 1'b0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("cap_word", {cap_sel, cap_data}, e);
               end
            end
         end
      end
   end

   // Test sequence.
   initial begin
      rst             = 1'b1;
      kernel_start    = 1'b0;
      bypass_adc_eval = 1'b0;
      gapMode         = 0;
      bypassModel     = 1'b0;
      for (int i = 0; i < 8; i++) coeffs[i] = 16'h8001 + 16'(i);
      for (int k = 0; k < NWORDS; k++) words[k] = (k % 2 == 0) ? 16'hA5C3 : 16'h1234;
      for (int s = 0; s < NS; s++) delays[s] = 10;
      #1;
      checkResetValues("por");
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      applyStimulus(1'b0);
      finishRun("nominal", 1'b0);

      for (int s = 0; s < NS; s++) delays[s] = 0;
      applyStimulus(1'b1);
      finishRun("timeout_never", 1'b0);

      for (int s = 0; s < NS; s++) delays[s] = TO;
      applyStimulus(1'b0);
      finishRun("same_cycle", 1'b0);

      for (int s = 0; s < NS; s++) delays[s] = 5;
      delays[2] = TO + 1;
      applyStimulus(1'b1);
      finishRun("late_step2", 1'b0);

      randomizeRun();
      gapMode = 1;
      applyStimulus(1'b1);
      finishRun("gapped_poke", 1'b1);

      randomizeRun();
      gapMode = 0;
      applyStimulus(1'b1);
      for (int n = 0; n < 3000 && bitsSent < 7; n++) begin
         @(posedge clk); #3;
      end
      checkOutput("midrst_bits_before_reset", bitsSent, 7);
      @(posedge clk); #3;
      rst = 1'b1;
      expQ.delete();
      #1;
      checkResetValues("midrst");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      randomizeRun();
      applyStimulus(1'b0);
      finishRun("after_reset", 1'b0);

      for (int r = 0; r < 4; r++) begin
         randomizeRun();
         if (r == 3) delays[$urandom_range(0, NS - 1)] = TO + 1 + $urandom_range(0, 3);
         gapMode = 2;
         applyStimulus(1'($urandom_range(0, 1)));
         finishRun($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
